// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences the shared datapath (single memory port, one ALU, IR/MDR/A/B/ALUOut)
// through FETCH, DECODE, EXEC, MEM and WB. Memory accesses stall on mem_ready_i.
//
// State table:
//   state  | meaning
//   FETCH  | read instruction at PC, PC+4 -> PC when memory is ready
//   DECODE | decode IR, ALU precomputes branch target into ALUOut, J/JAL finish here
//   EXEC   | ALU op / address calc / branch compare / JR, JALR finish here
//   MEM    | data access at ALUOut (LW read, SW write), held until ready
//   WB     | register file write-back
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   op_i, funct_i           IR[31:26], IR[5:0]
//   zero_i, sign_i          ALU status for branch decisions
//   mem_ready_i             memory completes the current request
//   mem_req_o .. wb_src_o   datapath controls (see select encodings below)
//   illegal_o               one-cycle pulse on an undecodable instruction
//   state_o                 current state, debug
module multicycle_ctrl #(
   parameter int STATE_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op_i,
   input  logic [5:0]         funct_i,
   input  logic               zero_i,
   input  logic               sign_i,
   input  logic               mem_ready_i,
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic               iord_o,
   output logic               ir_write_o,
   output logic               pc_write_o,
   output logic [1:0]         pc_src_o,
   output logic [1:0]         alu_srca_o,
   output logic [1:0]         alu_srcb_o,
   output logic [1:0]         ext_op_o,
   output logic [3:0]         alu_op_o,
   output logic               reg_write_o,
   output logic [1:0]         reg_dst_o,
   output logic [1:0]         wb_src_o,
   output logic               illegal_o,
   output logic [STATE_W-1:0] state_o
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = STATE_W'(0),
      S_DECODE = STATE_W'(1),
      S_EXEC   = STATE_W'(2),
      S_MEM    = STATE_W'(3),
      S_WB     = STATE_W'(4)
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SHL  = 4'd8;
   localparam logic [3:0] ALU_SHR  = 4'd9;
   localparam logic [3:0] ALU_SAR  = 4'd10;

   state_t state_r, state_next;

   logic       is_ralu, is_shift, is_jr, is_jalr, is_ialu;
   logic       is_lw, is_sw, is_br, is_j, is_jal, is_lui, legal;
   logic       br_taken;
   logic [3:0] dec_alu;
   logic [1:0] dec_ext;

   always_comb begin
      is_ralu  = 1'b0;
      is_shift = 1'b0;
      is_jr    = 1'b0;
      is_jalr  = 1'b0;
      is_ialu  = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_br    = 1'b0;
      is_j     = 1'b0;
      is_jal   = 1'b0;
      is_lui   = 1'b0;
      br_taken = 1'b0;
      dec_alu  = ALU_ADD;
      dec_ext  = 2'b00;
      case (op_i)
         6'h00: begin
            case (funct_i)
               6'h00: begin is_ralu = 1'b1; is_shift = 1'b1; dec_alu = ALU_SHL; end
               6'h02: begin is_ralu = 1'b1; is_shift = 1'b1; dec_alu = ALU_SHR; end
               6'h03: begin is_ralu = 1'b1; is_shift = 1'b1; dec_alu = ALU_SAR; end
               6'h08: is_jr = 1'b1;
               6'h09: is_jalr = 1'b1;
               6'h20, 6'h21: begin is_ralu = 1'b1; dec_alu = ALU_ADD; end
               6'h22, 6'h23: begin is_ralu = 1'b1; dec_alu = ALU_SUB; end
               6'h24: begin is_ralu = 1'b1; dec_alu = ALU_AND; end
               6'h25: begin is_ralu = 1'b1; dec_alu = ALU_OR;  end
               6'h26: begin is_ralu = 1'b1; dec_alu = ALU_XOR; end
               6'h27: begin is_ralu = 1'b1; dec_alu = ALU_NOR; end
               6'h2A: begin is_ralu = 1'b1; dec_alu = ALU_SLT; end
               6'h2B: begin is_ralu = 1'b1; dec_alu = ALU_SLTU; end
               default: ;
            endcase
         end
         6'h02: is_j = 1'b1;
         6'h03: is_jal = 1'b1;
         6'h04: begin is_br = 1'b1; br_taken = zero_i; end
         6'h05: begin is_br = 1'b1; br_taken = !zero_i; end
         6'h06: begin is_br = 1'b1; br_taken = zero_i | sign_i; end
         6'h07: begin is_br = 1'b1; br_taken = !zero_i & !sign_i; end
         6'h08, 6'h09: begin is_ialu = 1'b1; dec_alu = ALU_ADD; end
         6'h0A: begin is_ialu = 1'b1; dec_alu = ALU_SLT; end
         6'h0B: begin is_ialu = 1'b1; dec_alu = ALU_SLTU; end
         6'h0C: begin is_ialu = 1'b1; dec_alu = ALU_AND; dec_ext = 2'b01; end
         6'h0D: begin is_ialu = 1'b1; dec_alu = ALU_OR;  dec_ext = 2'b01; end
         6'h0E: begin is_ialu = 1'b1; dec_alu = ALU_XOR; dec_ext = 2'b01; end
         6'h0F: is_lui = 1'b1;
         6'h23: is_lw = 1'b1;
         6'h2B: is_sw = 1'b1;
         default: ;
      endcase
   end

   assign legal = is_ralu | is_jr | is_jalr | is_ialu | is_lw | is_sw |
                  is_br | is_j | is_jal | is_lui;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_FETCH;
      else        state_r <= state_next;
   end

   // Raw strobes are gated with rst_n below so nothing can fire while reset
   // is held, even though the state register already reads FETCH.
   logic mem_req, mem_we, ir_write, pc_write, reg_write, illegal;

   always_comb begin
      state_next = state_r;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      iord_o     = 1'b0;
      pc_src_o   = 2'b00;
      alu_srca_o = 2'b00;
      alu_srcb_o = 2'b00;
      ext_op_o   = 2'b00;
      alu_op_o   = ALU_ADD;
      reg_dst_o  = 2'b00;
      wb_src_o   = 2'b00;
      case (state_r)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_srcb_o = 2'b01;
            if (mem_ready_i) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_srcb_o = 2'b11;
            if (!legal) begin
               illegal    = 1'b1;
               state_next = S_FETCH;
            end else if (is_j || is_jal) begin
               pc_write   = 1'b1;
               pc_src_o   = 2'b10;
               state_next = S_FETCH;
               if (is_jal) begin
                  reg_write = 1'b1;
                  reg_dst_o = 2'b10;
                  wb_src_o  = 2'b10;
               end
            end else if (is_lui) begin
               state_next = S_WB;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            state_next = S_FETCH;
            if (is_ralu) begin
               alu_srca_o = is_shift ? 2'b10 : 2'b01;
               alu_op_o   = dec_alu;
               state_next = S_WB;
            end else if (is_ialu) begin
               alu_srca_o = 2'b01;
               alu_srcb_o = 2'b10;
               ext_op_o   = dec_ext;
               alu_op_o   = dec_alu;
               state_next = S_WB;
            end else if (is_lw || is_sw) begin
               alu_srca_o = 2'b01;
               alu_srcb_o = 2'b10;
               state_next = S_MEM;
            end else if (is_br) begin
               alu_srca_o = 2'b01;
               alu_op_o   = ALU_SUB;
               if (br_taken) begin
                  pc_write = 1'b1;
                  pc_src_o = 2'b01;
               end
            end else if (is_jr || is_jalr) begin
               pc_write = 1'b1;
               pc_src_o = 2'b11;
               if (is_jalr) begin
                  reg_write = 1'b1;
                  reg_dst_o = 2'b01;
                  wb_src_o  = 2'b10;
               end
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord_o  = 1'b1;
            mem_we  = is_sw;
            if (mem_ready_i) state_next = is_lw ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_write  = 1'b1;
            state_next = S_FETCH;
            if (is_ralu) begin
               reg_dst_o = 2'b01;
            end else if (is_lw) begin
               wb_src_o = 2'b01;
            end else if (is_lui) begin
               wb_src_o = 2'b11;
               ext_op_o = 2'b11;
            end
         end
         default: state_next = S_FETCH;
      endcase
   end

   assign mem_req_o   = mem_req   & rst_n;
   assign mem_we_o    = mem_we    & rst_n;
   assign ir_write_o  = ir_write  & rst_n;
   assign pc_write_o  = pc_write  & rst_n;
   assign reg_write_o = reg_write & rst_n;
   assign illegal_o   = illegal   & rst_n;
   assign state_o     = state_r;

endmodule
